// File: rtl/boot_loader_if.sv
// boot_loader_if: ROM read, RAM write, start request and CPU boot status of the boot copier.
interface boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_data;
  logic              ram_wr_en;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    input  start, rom_data,
    output rom_addr, ram_addr, ram_data, ram_wr_en, cpu_hold, busy, done, err
  );
  modport slave (
    output start, rom_data,
    input  rom_addr, ram_addr, ram_data, ram_wr_en, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: streams LEN ROM words into RAM after reset, holding the CPU until done.
// Define BOOT_CHECKSUM_EN to verify the ROM word after the image against a running sum.
module boot_loader #(
  parameter int ADDR_W   = 8,
  parameter int WORD_W   = 8,
  parameter int LEN      = 16,
  parameter int ROM_BASE = 0,
  parameter int RAM_BASE = 0
) (
  input logic           clk,
  input logic           rst_n,
  boot_loader_if.master bus_io
);
  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [ADDR_W-1:0] ROM0 = ADDR_W'(ROM_BASE);
  localparam logic [ADDR_W-1:0] RAM0 = ADDR_W'(RAM_BASE);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(LEN - 1);
`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {COPY, DRAIN, CHECK, DONE, FAIL} state_t;
  logic [WORD_W-1:0] sum_q, sum_d, exp_q, exp_d;
  logic              err_q, err_d;
`else
  typedef enum logic [1:0] {COPY, DRAIN, DONE} state_t;
`endif
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_data_q, ram_data_d;
  logic              wr_pend_q, wr_pend_d, hold_q, hold_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    rom_addr_d = rom_addr_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    wr_pend_d  = 1'b0;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d      = sum_q;
    exp_d      = exp_q;
    err_d      = err_q;
`endif
    case (state_q)
      COPY: begin
        ram_data_d = bus_io.rom_data;
        ram_addr_d = RAM0 + ADDR_W'(rd_cnt_q);
        wr_pend_d  = 1'b1;
        rd_cnt_d   = rd_cnt_q + 1'b1;
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = (rd_cnt_q == LAST) ? DRAIN : COPY;
`ifdef BOOT_CHECKSUM_EN
        sum_d      = sum_q + bus_io.rom_data;
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      // rom_addr already points one past the image: that word is the expected checksum
      DRAIN: begin
        exp_d   = bus_io.rom_data;
        state_d = CHECK;
      end
      CHECK: begin
        rom_addr_d = ROM0;
        busy_d     = 1'b0;
        hold_d     = sum_q != exp_q;
        done_d     = sum_q == exp_q;
        err_d      = sum_q != exp_q;
        state_d    = (sum_q == exp_q) ? DONE : FAIL;
      end
`else
      DRAIN: begin
        rom_addr_d = ROM0;
        hold_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = DONE;
      end
`endif
      default: if (bus_io.start) begin
        state_d    = COPY;
        rd_cnt_d   = '0;
        rom_addr_d = ROM0;
        hold_d     = 1'b1;
        busy_d     = 1'b1;
        done_d     = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_d      = '0;
        err_d      = 1'b0;
`endif
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COPY;
      rd_cnt_q   <= '0;
      rom_addr_q <= ROM0;
      ram_addr_q <= RAM0;
      ram_data_q <= '0;
      wr_pend_q  <= 1'b0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= '0;
      exp_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      rom_addr_q <= rom_addr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      wr_pend_q  <= wr_pend_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= sum_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
`endif
    end
  end
  assign bus_io.rom_addr  = rom_addr_q;
  assign bus_io.ram_addr  = ram_addr_q;
  assign bus_io.ram_data  = ram_data_q;
  assign bus_io.ram_wr_en = wr_pend_q;
  assign bus_io.cpu_hold  = hold_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.done      = done_q;
`ifdef BOOT_CHECKSUM_EN
  assign bus_io.err       = err_q;
`else
  assign bus_io.err       = 1'b0;
`endif
endmodule
